// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and the bridge
// address decoder that selects it.
//   - register word offsets (Addr[1:0])
//   - CTRL and STATUS bit positions
//   - transmitter FSM state encoding
//   - pack_status(): assembles the STATUS read word
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int COUNT_W        = 5;  // holds 0..16 entries

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [31:0] pack_status(
    input logic               empty,
    input logic               full,
    input logic               busy,
    input logic               ovf,
    input logic [COUNT_W-1:0] count
  );
    logic [31:0] s;
    s = '0;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    s[STAT_COUNT_LSB +: COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (empties the FIFO)
//   push, din       write a byte; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   pop             remove the head byte (ignored when empty)
//   head            current head byte (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored bytes
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         head,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               push_ok, pop_ok;

  assign full    = (count_reg == COUNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // The transmitter must latch the head byte in the same cycle it pops,
  // so the head is read straight from the array.
  assign head    = mem[rd_ptr_reg];

  // When full, a concurrent pop frees the slot being written this cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   Addr         word address from the bridge; only Addr[1:0] decoded
//   WE           write enable (already qualified for this device)
//   Din, Dout    write data / combinational read data
//   IRQ          registered level interrupt: IRQEN & EMPTY & ~BUSY
//   tx           serial output, idle high
// Registers: 0 DATA (W push), 1 CTRL (TXEN, IRQEN), 2 DIVISOR[15:0]
// (bit period = DIVISOR+1 clocks), 3 STATUS (R flags/count, W clears OVF).
import uart_pkg::*;

module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  logic [1:0]  ctrl_reg;
  logic [15:0] div_reg;
  logic        ovf_reg;

  tx_state_t   state_reg;
  logic [15:0] cnt_reg;
  logic [15:0] div_lat_reg;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx_reg;
  logic        tx_reg;
  logic        irq_reg;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_head;
  logic [COUNT_W-1:0] fifo_count;

  logic [1:0] reg_sel;
  logic       txen, irqen, busy, bit_done, start_frame;
  logic       unused_bits;

  assign reg_sel  = Addr[1:0];
  assign txen     = ctrl_reg[CTRL_TXEN];
  assign irqen    = ctrl_reg[CTRL_IRQEN];
  assign busy     = (state_reg != S_IDLE);
  assign bit_done = (cnt_reg == 16'd0);

  // A frame starts from IDLE, or straight out of the last STOP clock so
  // back-to-back bytes leave no idle gap.
  assign start_frame = txen && !fifo_empty &&
                       ((state_reg == S_IDLE) ||
                        (state_reg == S_STOP && bit_done));

  assign fifo_push = WE && (reg_sel == REG_DATA);
  assign fifo_pop  = start_frame;

  assign unused_bits = ^{Addr[29:2], Din[31:16]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (Din[7:0]),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg <= '0;
      div_reg  <= DIV_RESET;
      ovf_reg  <= 1'b0;
    end else if (WE) begin
      case (reg_sel)
        REG_DATA:   if (fifo_full && !fifo_pop) ovf_reg <= 1'b1;
        REG_CTRL:   ctrl_reg <= Din[1:0];
        REG_DIV:    div_reg  <= Din[15:0];
        REG_STATUS: ovf_reg  <= 1'b0;
        default:    ;
      endcase
    end
  end

  // Transmit FSM. Every state lasts latched-DIVISOR+1 clocks per bit; the
  // divisor is captured at frame start so mid-frame writes wait a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      div_lat_reg <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_frame) begin
            state_reg   <= S_START;
            shift_reg   <= fifo_head;
            div_lat_reg <= div_reg;
            cnt_reg     <= div_reg;
            tx_reg      <= 1'b0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state_reg   <= S_DATA;
            cnt_reg     <= div_lat_reg;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_reg <= div_lat_reg;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (start_frame) begin
              state_reg   <= S_START;
              shift_reg   <= fifo_head;
              div_lat_reg <= div_reg;
              cnt_reg     <= div_reg;
              tx_reg      <= 1'b0;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= irqen && fifo_empty && !busy;
  end

  assign tx  = tx_reg;
  assign IRQ = irq_reg;

  always_comb begin
    Dout = '0;
    case (reg_sel)
      REG_CTRL:   Dout = {30'd0, ctrl_reg};
      REG_DIV:    Dout = {16'd0, div_reg};
      REG_STATUS: Dout = pack_status(fifo_empty, fifo_full, busy, ovf_reg,
                                     fifo_count);
      default:    Dout = '0;
    endcase
  end

endmodule
